// File: rtl/tex_pkg.sv
// Shared types and widths for the texture coordinate scheduler and its
// neighbours (sampler front ends, cache tag lookup).
package tex_pkg;

  localparam int TEX_COORD_W = 15;  // unsigned Q0.15 s/t
  localparam int TEX_DIM_W   = 11;  // texture width/height, texel x/y
  localparam int TEX_IDX_W   = 22;  // linear texel index
  localparam int TEX_ID_W    = 3;   // room for up to 8 requesters
  localparam int TEX_PROD_W  = TEX_COORD_W + TEX_DIM_W;

  typedef struct packed {
    logic [TEX_COORD_W-1:0] s;
    logic [TEX_COORD_W-1:0] t;
    logic [TEX_DIM_W-1:0]   width;
    logic [TEX_DIM_W-1:0]   height;
  } tex_req_t;

  typedef struct packed {
    logic [TEX_ID_W-1:0]  id;
    logic [TEX_DIM_W-1:0] x;
    logic [TEX_DIM_W-1:0] y;
    logic [TEX_IDX_W-1:0] index;
  } tex_res_t;

  // Scale a normalized coordinate by a texture dimension, truncating the
  // fraction. Because the coordinate is below 1.0 the result is below dim.
  function automatic logic [TEX_DIM_W-1:0] tex_scale(
    input logic [TEX_COORD_W-1:0] c,
    input logic [TEX_DIM_W-1:0]   dim
  );
    logic [TEX_PROD_W-1:0] p;
    p = TEX_PROD_W'(c) * TEX_PROD_W'(dim);
    return p[TEX_PROD_W-1:TEX_COORD_W];
  endfunction

endpackage

// File: rtl/tex_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer
// (wrapping) and moves the pointer past the winner when adv is high.
// The grant is raw; the caller qualifies it with its own accept condition.
module tex_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  // Scan N positions starting at the pointer; first set request wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = |req;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
      idx = sum[ID_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // Pointer moves to the slot after the winner only on an actual grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (adv) ptr <= (grant_id == ID_W'(N-1)) ? '0 : grant_id + 1'b1;
  end

endmodule

// File: rtl/tex_coord_sched.sv
// Texture coordinate scheduler: round-robin over NUM_REQ samplers into a
// 2-stage s/t -> texel x/y -> linear index pipeline with valid/ready on
// both sides. Optional perf counters under TEX_SCHED_PERF_EN.
module tex_coord_sched
  import tex_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                           core_clock_i,
  input  logic                           core_reset_n_i,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*TEX_COORD_W-1:0] req_s_i,
  input  logic [NUM_REQ*TEX_COORD_W-1:0] req_t_i,
  input  logic [NUM_REQ*TEX_DIM_W-1:0]   req_width_i,
  input  logic [NUM_REQ*TEX_DIM_W-1:0]   req_height_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [ID_W-1:0]                out_id_o,
  output logic [TEX_DIM_W-1:0]           out_x_o,
  output logic [TEX_DIM_W-1:0]           out_y_o,
  output logic [TEX_IDX_W-1:0]           out_index_o
`ifdef TEX_SCHED_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]          perf_grants_o,
  output logic [15:0]                    perf_stall_o
`endif
);

  localparam int STAGES = 2;

  tex_req_t [NUM_REQ-1:0] req_vec;
  tex_req_t               sel;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        win_id;
  logic                   any_req;
  logic [STAGES:1]        vld_pipe;
  logic                   s1_en, s2_en, accept;

  logic [TEX_ID_W-1:0]    s1_id;
  logic [TEX_DIM_W-1:0]   s1_x, s1_y, s1_w;
  logic [TEX_IDX_W-1:0]   idx_nxt;
  tex_res_t               s2_res;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req_vec[i].s      = req_s_i[TEX_COORD_W*i +: TEX_COORD_W];
    assign req_vec[i].t      = req_t_i[TEX_COORD_W*i +: TEX_COORD_W];
    assign req_vec[i].width  = req_width_i[TEX_DIM_W*i +: TEX_DIM_W];
    assign req_vec[i].height = req_height_i[TEX_DIM_W*i +: TEX_DIM_W];
  end

  // A stage may take new data when empty or when its contents move on.
  // Reset gates accept so ready drops the moment reset asserts.
  assign s2_en  = !vld_pipe[2] || out_ready_i;
  assign s1_en  = !vld_pipe[1] || s2_en;
  assign accept = s1_en && !flush_i && any_req && core_reset_n_i;

  tex_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (core_clock_i),
    .rst_n    (core_reset_n_i),
    .req      (req_valid_i),
    .adv      (accept),
    .grant    (grant),
    .grant_id (win_id),
    .any      (any_req)
  );

  assign req_ready_o = grant & {NUM_REQ{accept}};
  assign sel         = req_vec[win_id];
  assign idx_nxt     = TEX_IDX_W'(s1_y) * TEX_IDX_W'(s1_w) + TEX_IDX_W'(s1_x);

  // Valid bits: flush empties both stages; otherwise each stage refills
  // from its predecessor whenever it is allowed to advance.
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) vld_pipe <= '0;
    else if (flush_i)    vld_pipe <= '0;
    else begin
      if (s2_en) vld_pipe[2] <= vld_pipe[1];
      if (s1_en) vld_pipe[1] <= accept;
    end
  end

  // Stage 1: scale s/t to texel x/y and keep width for the index multiply.
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      s1_id <= '0;
      s1_x  <= '0;
      s1_y  <= '0;
      s1_w  <= '0;
    end else if (accept) begin
      s1_id <= TEX_ID_W'(win_id);
      s1_x  <= tex_scale(sel.s, sel.width);
      s1_y  <= tex_scale(sel.t, sel.height);
      s1_w  <= sel.width;
    end
  end

  // Stage 2: linear index; data only moves on a real transfer so a
  // stalled result stays stable on the outputs.
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) s2_res <= '0;
    else if (!flush_i && s2_en && vld_pipe[1]) begin
      s2_res.id    <= s1_id;
      s2_res.x     <= s1_x;
      s2_res.y     <= s1_y;
      s2_res.index <= idx_nxt;
    end
  end

  assign out_valid_o = vld_pipe[2];
  assign out_id_o    = ID_W'(s2_res.id);
  assign out_x_o     = s2_res.x;
  assign out_y_o     = s2_res.y;
  assign out_index_o = s2_res.index;

`ifdef TEX_SCHED_PERF_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;
  logic [15:0]              stall_cnt;

  // Saturating grant and output-stall counters; flush does not touch them.
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready_o[i] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      if (out_valid_o && !out_ready_i && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign perf_grants_o = grant_cnt;
  assign perf_stall_o  = stall_cnt;
`endif

endmodule
